// File: rtl/d_branch_sched_if.sv
// Decode-stage branch scheduler bus: decode/E/M hazard inputs, comparator
// handshake, fetch redirect and statistics counters.
interface d_branch_sched_if #(
    parameter int CNT_W = 16
);
    logic             D_valid;
    logic             D_branch;
    logic [4:0]       D_rs_addr;
    logic [4:0]       D_rt_addr;
    logic [31:0]      D_target;
    logic             E_wr_en;
    logic [4:0]       E_wr_addr;
    logic             E_is_load;
    logic             M_wr_en;
    logic [4:0]       M_wr_addr;
    logic             M_is_load;
    logic             flush;
    logic             cmp_taken;
    logic             stall;
    logic             cmp_en;
    logic             redirect;
    logic [31:0]      redirect_pc;
    logic [CNT_W-1:0] branch_cnt;
    logic [CNT_W-1:0] taken_cnt;

    modport master (
        output D_valid, D_branch, D_rs_addr, D_rt_addr, D_target,
               E_wr_en, E_wr_addr, E_is_load, M_wr_en, M_wr_addr, M_is_load,
               flush, cmp_taken,
        input  stall, cmp_en, redirect, redirect_pc, branch_cnt, taken_cnt
    );

    modport slave (
        input  D_valid, D_branch, D_rs_addr, D_rt_addr, D_target,
               E_wr_en, E_wr_addr, E_is_load, M_wr_en, M_wr_addr, M_is_load,
               flush, cmp_taken,
        output stall, cmp_en, redirect, redirect_pc, branch_cnt, taken_cnt
    );
endinterface

// File: rtl/d_branch_sched.sv
// Decode-stage branch scheduler: stalls decode on E/M operand hazards, strobes
// the comparator once operands are forwardable and registers the PC redirect.
//
// state | meaning
// IDLE  | accept a branch; resolve at once or take the first stall cycle
// WAIT  | further stall cycles, cnt_q = stall cycles remaining after this one
// RES   | operands forwardable; comparator strobed, decode released
module d_branch_sched #(
    parameter int CNT_W      = 16,
    parameter int ALU_STALL  = 1,
    parameter int LOAD_STALL = 2
) (
    input logic             clk,
    input logic             reset,
    d_branch_sched_if.slave bus
);
    localparam int REQ_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RES  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [REQ_W-1:0] cnt_q, cnt_d;
    logic             redirect_q, redirect_d;
    logic [31:0]      redirect_pc_q, redirect_pc_d;
    logic [CNT_W-1:0] branch_cnt_q, branch_cnt_d;
    logic [CNT_W-1:0] taken_cnt_q, taken_cnt_d;

    logic             e_hit, m_hit;
    logic [REQ_W-1:0] req, e_req;
    logic             stall, cmp_en;

    always_comb begin
        e_hit = bus.E_wr_en &&
                ((bus.D_rs_addr != 5'd0 && bus.D_rs_addr == bus.E_wr_addr) ||
                 (bus.D_rt_addr != 5'd0 && bus.D_rt_addr == bus.E_wr_addr));
        m_hit = bus.M_wr_en &&
                ((bus.D_rs_addr != 5'd0 && bus.D_rs_addr == bus.M_wr_addr) ||
                 (bus.D_rt_addr != 5'd0 && bus.D_rt_addr == bus.M_wr_addr));
        e_req = bus.E_is_load ? REQ_W'(LOAD_STALL) : REQ_W'(ALU_STALL);
        req   = (m_hit && bus.M_is_load) ? REQ_W'(1) : REQ_W'(0);
        if (e_hit && e_req > req) req = e_req;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stall   = 1'b0;
        cmp_en  = 1'b0;
        // Reset is folded in so the outputs drop the moment it is asserted.
        if (bus.flush || reset) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.D_valid && bus.D_branch) begin
                        if (req == '0) begin
                            cmp_en = 1'b1;
                        end else begin
                            stall = 1'b1;
                            if (req == REQ_W'(1)) begin
                                state_d = RES;
                            end else begin
                                cnt_d   = req - REQ_W'(2);
                                state_d = WAIT;
                            end
                        end
                    end
                end
                WAIT: begin
                    stall = 1'b1;
                    if (cnt_q == '0) state_d = RES;
                    else             cnt_d   = cnt_q - REQ_W'(1);
                end
                RES: begin
                    cmp_en  = 1'b1;
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_comb begin
        redirect_d    = cmp_en && bus.cmp_taken;
        redirect_pc_d = redirect_pc_q;
        branch_cnt_d  = branch_cnt_q;
        taken_cnt_d   = taken_cnt_q;
        if (cmp_en) begin
            branch_cnt_d = branch_cnt_q + CNT_W'(1);
            if (bus.cmp_taken) begin
                redirect_pc_d = bus.D_target;
                taken_cnt_d   = taken_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            redirect_q    <= 1'b0;
            redirect_pc_q <= '0;
            branch_cnt_q  <= '0;
            taken_cnt_q   <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            redirect_q    <= redirect_d;
            redirect_pc_q <= redirect_pc_d;
            branch_cnt_q  <= branch_cnt_d;
            taken_cnt_q   <= taken_cnt_d;
        end
    end

    assign bus.stall       = stall;
    assign bus.cmp_en      = cmp_en;
    assign bus.redirect    = redirect_q;
    assign bus.redirect_pc = redirect_pc_q;
    assign bus.branch_cnt  = branch_cnt_q;
    assign bus.taken_cnt   = taken_cnt_q;
endmodule
